// File: rtl/dma_sched_pkg.sv
// Shared types and default widths for the DMA descriptor scheduler.
package dma_sched_pkg;
  localparam int DMA_DEPTH    = 4;
  localparam int DMA_ADDR_W   = 64;
  localparam int DMA_LEN_W    = 32;
  localparam int DMA_START_TO = 64;

  typedef enum logic {DIR_RX = 1'b0, DIR_TX = 1'b1} dir_e;
  typedef enum logic [1:0] {IDLE, START, RUN} eng_state_e;

  typedef struct packed {
    dir_e                  dir;
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_LEN_W-1:0]  len;
  } desc_t;
endpackage

// File: rtl/desc_fifo.sv
// Descriptor FIFO: registered storage, head visible only after the push edge.
module desc_fifo
  import dma_sched_pkg::*;
#(
  parameter int DEPTH = DMA_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  desc_t                  wdata,
  output desc_t                  head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  desc_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic           push_ok, pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/dma_desc_sched.sv
// In-order descriptor dispatcher for the RX/TX DMA engines with completion count and start timeout.
// Optional interrupt output built only when DMA_SCHED_IRQ_EN is defined.
module dma_desc_sched
  import dma_sched_pkg::*;
#(
  parameter int DEPTH    = DMA_DEPTH,
  parameter int ADDR_W   = DMA_ADDR_W,
  parameter int LEN_W    = DMA_LEN_W,
  parameter int START_TO = DMA_START_TO
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic                   desc_dir,
  input  logic [ADDR_W-1:0]      desc_addr,
  input  logic [LEN_W-1:0]       desc_len,
  input  logic                   flush,
  output logic                   start_rx,
  output logic [ADDR_W-1:0]      src_addr_rx,
  output logic [LEN_W-1:0]       len_pkts_rx,
  input  logic                   busy_rx,
  input  logic                   done_rx,
  output logic                   start_tx,
  output logic [ADDR_W-1:0]      dst_addr_tx,
  output logic [LEN_W-1:0]       len_pkts_tx,
  input  logic                   busy_tx,
  input  logic                   done_tx,
  output logic [$clog2(DEPTH):0] q_count,
  output logic [15:0]            cpl_count,
  output logic                   err,
  input  logic                   err_clr,
  output logic                   irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(START_TO + 1);

  desc_t             wdata, head;
  logic              full, empty, push, pop, zlen_pop;
  logic [ADDR_W-1:0] head_addr;
  logic [LEN_W-1:0]  head_len;

  logic [1:0]             busy_v, done_v, idle_v, start_v, cpl_v, tmo_v;
  logic [1:0][ADDR_W-1:0] addr_v;
  logic [1:0][LEN_W-1:0]  len_v;

  assign desc_ready = !full && !flush;
  assign push       = desc_valid && desc_ready;

  assign wdata.dir  = dir_e'(desc_dir);
  assign wdata.addr = DMA_ADDR_W'(desc_addr);
  assign wdata.len  = DMA_LEN_W'(desc_len);
  assign head_addr  = ADDR_W'(head.addr);
  assign head_len   = LEN_W'(head.len);

  // A head blocked on a busy engine stalls everything behind it.
  assign pop      = !empty && !flush && idle_v[head.dir];
  assign zlen_pop = pop && (head_len == '0);

  desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  assign busy_v = {busy_tx, busy_rx};
  assign done_v = {done_tx, done_rx};

`ifdef DMA_SCHED_IRQ_EN
  logic [1:0] idle_nxt_v;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_eng
    localparam logic DIR = (g == 1);

    eng_state_e        st, st_nxt;
    logic [TW-1:0]     tmo_cnt, tmo_nxt;
    logic              start_q, start_nxt, load, sel, cpl, tmo;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;

    assign sel = pop && (logic'(head.dir) == DIR);

    always_comb begin
      st_nxt    = st;
      start_nxt = start_q;
      tmo_nxt   = tmo_cnt;
      load      = 1'b0;
      cpl       = 1'b0;
      tmo       = 1'b0;
      case (st)
        IDLE: if (sel && !zlen_pop) begin
          st_nxt    = START;
          start_nxt = 1'b1;
          tmo_nxt   = '0;
          load      = 1'b1;
        end
        START: if (busy_v[g]) begin
          st_nxt    = RUN;
          start_nxt = 1'b0;
        end else if (tmo_cnt == TW'(START_TO - 1)) begin
          st_nxt    = IDLE;
          start_nxt = 1'b0;
          tmo       = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
        RUN: if (done_v[g] || !busy_v[g]) begin
          st_nxt = IDLE;
          cpl    = 1'b1;
        end
        default: st_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        st      <= IDLE;
        start_q <= 1'b0;
        tmo_cnt <= '0;
        addr_q  <= '0;
        len_q   <= '0;
      end else begin
        st      <= st_nxt;
        start_q <= start_nxt;
        tmo_cnt <= tmo_nxt;
        if (load) begin
          addr_q <= head_addr;
          len_q  <= head_len;
        end
      end
    end

    assign idle_v[g]  = (st == IDLE);
    assign start_v[g] = start_q;
    assign addr_v[g]  = addr_q;
    assign len_v[g]   = len_q;
    assign cpl_v[g]   = cpl;
    assign tmo_v[g]   = tmo;
`ifdef DMA_SCHED_IRQ_EN
    assign idle_nxt_v[g] = (st_nxt == IDLE);
`endif
  end

  assign start_rx    = start_v[0];
  assign src_addr_rx = addr_v[0];
  assign len_pkts_rx = len_v[0];
  assign start_tx    = start_v[1];
  assign dst_addr_tx = addr_v[1];
  assign len_pkts_tx = len_v[1];

  // At most two completions per edge: a zero-length pop needs its own engine idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cpl_count <= '0;
    else       cpl_count <= cpl_count + 16'(cpl_v[0]) + 16'(cpl_v[1]) + 16'(zlen_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        err <= 1'b0;
    else if (|tmo_v)  err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

`ifdef DMA_SCHED_IRQ_EN
  logic q_empty_nxt, irq_set;

  assign q_empty_nxt = flush || (!push && (q_count == {{(CW-1){1'b0}}, pop}));
  assign irq_set     = (|cpl_v || zlen_pop || |tmo_v) && q_empty_nxt && &idle_nxt_v;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                irq <= 1'b0;
    else if (irq_set)         irq <= 1'b1;
    else if (push || err_clr) irq <= 1'b0;
  end
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed bench for dma_desc_sched: dispatch order, timeout, flush, reset and completion counting.
module tb_dma_desc_sched;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        desc_valid = 1'b0, desc_dir = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [63:0] desc_addr = '0;
  logic [31:0] desc_len = '0;
  logic        busy_rx = 1'b0, done_rx = 1'b0, busy_tx = 1'b0, done_tx = 1'b0;
  logic        desc_ready, start_rx, start_tx, err, irq;
  logic [63:0] src_addr_rx, dst_addr_tx;
  logic [31:0] len_pkts_rx, len_pkts_tx;
  logic [2:0]  q_count;
  logic [15:0] cpl_count;
  int checks = 0, failures = 0;

`ifdef DMA_SCHED_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  dma_desc_sched dut (
    .clk(clk), .rstn(rstn), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_dir(desc_dir), .desc_addr(desc_addr), .desc_len(desc_len), .flush(flush),
    .start_rx(start_rx), .src_addr_rx(src_addr_rx), .len_pkts_rx(len_pkts_rx),
    .busy_rx(busy_rx), .done_rx(done_rx),
    .start_tx(start_tx), .dst_addr_tx(dst_addr_tx), .len_pkts_tx(len_pkts_tx),
    .busy_tx(busy_tx), .done_tx(done_tx),
    .q_count(q_count), .cpl_count(cpl_count), .err(err), .err_clr(err_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_desc(input logic dir, input logic [63:0] addr, input logic [31:0] len);
    desc_valid = 1'b1; desc_dir = dir; desc_addr = addr; desc_len = len;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q_count); end
    checks++; if (cpl_count !== 16'd0) begin failures++; $display("FAIL reset_cpl got=%0d exp=0", cpl_count); end
    checks++; if ({start_rx, start_tx, err, irq} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {start_rx, start_tx, err, irq}); end
    checks++; if (src_addr_rx !== 64'd0 || dst_addr_tx !== 64'd0) begin failures++; $display("FAIL reset_addr got=%h/%h exp=0", src_addr_rx, dst_addr_tx); end
    checks++; if (desc_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", desc_ready); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_desc(1'b0, 64'h1000, 32'd3);
    tick(); desc_valid = 1'b0;
    checks++; if (q_count !== 3'd1 || start_rx !== 1'b0) begin failures++; $display("FAIL single_accept got q=%0d st=%b exp q=1 st=0", q_count, start_rx); end
    tick();
    checks++; if (start_rx !== 1'b1 || q_count !== 3'd0) begin failures++; $display("FAIL single_start got st=%b q=%0d exp st=1 q=0", start_rx, q_count); end
    checks++; if (src_addr_rx !== 64'h1000 || len_pkts_rx !== 32'd3) begin failures++; $display("FAIL single_load got %h/%0d exp 1000/3", src_addr_rx, len_pkts_rx); end
    tick();
    checks++; if (start_rx !== 1'b1) begin failures++; $display("FAIL single_hold got=%b exp=1", start_rx); end
    busy_rx = 1'b1;
    tick();
    checks++; if (start_rx !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", start_rx); end
    repeat (9) tick();
    checks++; if (cpl_count !== 16'd0) begin failures++; $display("FAIL single_early_cpl got=%0d exp=0", cpl_count); end
    done_rx = 1'b1;
    tick(); done_rx = 1'b0; busy_rx = 1'b0;
    checks++; if (cpl_count !== 16'd1 || src_addr_rx !== 64'h1000) begin failures++; $display("FAIL single_cpl got %0d/%h exp 1/1000", cpl_count, src_addr_rx); end
    checks++; if (irq !== IRQ_ON) begin failures++; $display("FAIL single_irq got=%b exp=%b", irq, IRQ_ON); end
  endtask

  task automatic test_in_order();
    set_desc(1'b0, 64'h2000, 32'd5);
    tick();
    checks++; if (q_count !== 3'd1 || irq !== 1'b0) begin failures++; $display("FAIL order_a got q=%0d irq=%b exp q=1 irq=0", q_count, irq); end
    set_desc(1'b0, 64'h3000, 32'd6);
    tick();
    checks++; if (q_count !== 3'd1 || start_rx !== 1'b1 || src_addr_rx !== 64'h2000) begin failures++; $display("FAIL order_b got q=%0d st=%b a=%h exp 1/1/2000", q_count, start_rx, src_addr_rx); end
    set_desc(1'b1, 64'h4000, 32'd7);
    tick(); desc_valid = 1'b0;
    checks++; if (q_count !== 3'd2) begin failures++; $display("FAIL order_c got q=%0d exp=2", q_count); end
    busy_rx = 1'b1;
    tick();
    checks++; if (start_rx !== 1'b0) begin failures++; $display("FAIL order_run got=%b exp=0", start_rx); end
    repeat (3) tick();
    checks++; if (start_tx !== 1'b0 || q_count !== 3'd2) begin failures++; $display("FAIL order_stall got st=%b q=%0d exp 0/2", start_tx, q_count); end
    done_rx = 1'b1;
    tick(); done_rx = 1'b0;
    checks++; if (cpl_count !== 16'd2 || q_count !== 3'd2) begin failures++; $display("FAIL order_cpl_a got %0d/%0d exp 2/2", cpl_count, q_count); end
    tick();
    checks++; if (start_rx !== 1'b1 || src_addr_rx !== 64'h3000 || len_pkts_rx !== 32'd6 || q_count !== 3'd1) begin failures++; $display("FAIL order_pop_b got st=%b a=%h l=%0d q=%0d", start_rx, src_addr_rx, len_pkts_rx, q_count); end
    tick();
    checks++; if (start_tx !== 1'b1 || dst_addr_tx !== 64'h4000 || len_pkts_tx !== 32'd7 || q_count !== 3'd0 || start_rx !== 1'b0) begin failures++; $display("FAIL order_pop_c got st=%b a=%h l=%0d q=%0d srx=%b", start_tx, dst_addr_tx, len_pkts_tx, q_count, start_rx); end
    busy_tx = 1'b1;
    tick();
    checks++; if (start_tx !== 1'b0) begin failures++; $display("FAIL order_tx_run got=%b exp=0", start_tx); end
    done_rx = 1'b1; done_tx = 1'b1;
    tick(); done_rx = 1'b0; done_tx = 1'b0; busy_rx = 1'b0; busy_tx = 1'b0;
    checks++; if (cpl_count !== 16'd4) begin failures++; $display("FAIL order_dual_cpl got=%0d exp=4", cpl_count); end
  endtask

  task automatic test_zero_len();
    set_desc(1'b1, 64'h5000, 32'd0);
    tick(); desc_valid = 1'b0;
    checks++; if (cpl_count !== 16'd4 || q_count !== 3'd1) begin failures++; $display("FAIL zlen_accept got %0d/%0d exp 4/1", cpl_count, q_count); end
    tick();
    checks++; if (cpl_count !== 16'd5 || start_tx !== 1'b0 || dst_addr_tx !== 64'h4000 || q_count !== 3'd0) begin failures++; $display("FAIL zlen_pop got c=%0d st=%b a=%h q=%0d", cpl_count, start_tx, dst_addr_tx, q_count); end
    checks++; if (irq !== IRQ_ON) begin failures++; $display("FAIL zlen_irq got=%b exp=%b", irq, IRQ_ON); end
    tick();
    checks++; if (start_tx !== 1'b0) begin failures++; $display("FAIL zlen_nostart got=%b exp=0", start_tx); end
  endtask

  task automatic test_timeout();
    set_desc(1'b0, 64'h6000, 32'd2);
    tick(); desc_valid = 1'b0;
    tick();
    repeat (63) tick();
    checks++; if (err !== 1'b0 || start_rx !== 1'b1) begin failures++; $display("FAIL tmo_edge got err=%b st=%b exp 0/1", err, start_rx); end
    tick();
    checks++; if (err !== 1'b1 || start_rx !== 1'b0 || cpl_count !== 16'd5) begin failures++; $display("FAIL tmo_fire got err=%b st=%b c=%0d exp 1/0/5", err, start_rx, cpl_count); end
    checks++; if (irq !== IRQ_ON) begin failures++; $display("FAIL tmo_irq got=%b exp=%b", irq, IRQ_ON); end
    set_desc(1'b0, 64'h6100, 32'd2);
    tick(); desc_valid = 1'b0;
    tick();
    repeat (63) tick();
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_clr_race got=%b exp=1", err); end
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    checks++; if (err !== 1'b0 || irq !== 1'b0 || cpl_count !== 16'd5) begin failures++; $display("FAIL tmo_clr got err=%b irq=%b c=%0d exp 0/0/5", err, irq, cpl_count); end
  endtask

  task automatic test_full_flush();
    set_desc(1'b1, 64'h7000, 32'd9);
    tick();
    set_desc(1'b1, 64'h8000, 32'd1);
    tick();
    busy_tx = 1'b1;
    set_desc(1'b1, 64'h8100, 32'd1);
    tick();
    set_desc(1'b1, 64'h8200, 32'd1);
    tick();
    set_desc(1'b1, 64'h8300, 32'd1);
    tick();
    checks++; if (q_count !== 3'd4 || desc_ready !== 1'b0) begin failures++; $display("FAIL full got q=%0d rdy=%b exp 4/0", q_count, desc_ready); end
    set_desc(1'b1, 64'h8400, 32'd1);
    tick();
    checks++; if (q_count !== 3'd4) begin failures++; $display("FAIL full_5th got q=%0d exp=4", q_count); end
    flush = 1'b1;
    tick();
    checks++; if (q_count !== 3'd0 || dst_addr_tx !== 64'h7000 || start_tx !== 1'b0) begin failures++; $display("FAIL flush got q=%0d a=%h st=%b exp 0/7000/0", q_count, dst_addr_tx, start_tx); end
    checks++; if (desc_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", desc_ready); end
    tick();
    checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL flush_push got q=%0d exp=0", q_count); end
    flush = 1'b0; desc_valid = 1'b0;
    #1;
    checks++; if (desc_ready !== 1'b1) begin failures++; $display("FAIL flush_release got=%b exp=1", desc_ready); end
    done_tx = 1'b1;
    tick(); done_tx = 1'b0; busy_tx = 1'b0;
    checks++; if (cpl_count !== 16'd6) begin failures++; $display("FAIL flush_cpl got=%0d exp=6", cpl_count); end
  endtask

  task automatic test_reset_mid();
    set_desc(1'b0, 64'h9000, 32'd4);
    tick(); desc_valid = 1'b0;
    tick();
    busy_rx = 1'b1;
    tick();
    checks++; if (start_rx !== 1'b0 || src_addr_rx !== 64'h9000) begin failures++; $display("FAIL rstmid_run got st=%b a=%h exp 0/9000", start_rx, src_addr_rx); end
    rstn = 1'b0;
    #1;
    checks++; if (src_addr_rx !== 64'd0 || len_pkts_rx !== 32'd0 || cpl_count !== 16'd0 || q_count !== 3'd0 || {start_rx, err, irq} !== 3'b0) begin failures++; $display("FAIL rstmid_async got a=%h l=%0d c=%0d q=%0d", src_addr_rx, len_pkts_rx, cpl_count, q_count); end
    busy_rx = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    set_desc(1'b1, 64'hA000, 32'd0);
    tick();
    checks++; if (cpl_count !== 16'd0 || q_count !== 3'd1) begin failures++; $display("FAIL b2b_first got %0d/%0d exp 0/1", cpl_count, q_count); end
    tick();
    checks++; if (cpl_count !== 16'd1 || q_count !== 3'd1) begin failures++; $display("FAIL b2b_second got %0d/%0d exp 1/1", cpl_count, q_count); end
    tick(); desc_valid = 1'b0;
    tick();
    checks++; if (cpl_count !== 16'd3 || q_count !== 3'd0 || start_tx !== 1'b0) begin failures++; $display("FAIL b2b_end got c=%0d q=%0d st=%b exp 3/0/0", cpl_count, q_count, start_tx); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_in_order();
    test_zero_len();
    test_timeout();
    test_full_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
